// File: rtl/mem_resp_pkg.sv
// Shared constants, access-kind enum and counter helper for the memory responder.
package mem_resp_pkg;

  localparam int unsigned DefAddrW = 6;
  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefDepth = 48;
  localparam int unsigned CntW     = 8;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    REJECT
  } acc_kind_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between a requester (master) and the memory responder (slave).
interface mem_responder_if #(
  parameter int unsigned ADDR_W = mem_resp_pkg::DefAddrW,
  parameter int unsigned DATA_W = mem_resp_pkg::DefDataW
);

  logic                          en;
  logic                          wr;
  logic [ADDR_W-1:0]             addr;
  logic [DATA_W-1:0]             wdata;
  logic [DATA_W-1:0]             rdata;
  logic                          rvalid;
  logic                          wack;
  logic                          err;
  logic [mem_resp_pkg::CntW-1:0] wr_cnt;
  logic [mem_resp_pkg::CntW-1:0] rd_cnt;

  modport master (
    output en, wr, addr, wdata,
    input  rdata, rvalid, wack, err, wr_cnt, rd_cnt
  );

  modport slave (
    input  en, wr, addr, wdata,
    output rdata, rvalid, wack, err, wr_cnt, rd_cnt
  );

endinterface

// File: rtl/mem_array.sv
// DEPTH x DATA_W storage: one synchronous write port, one registered read port,
// synchronous clear of every word and of the read register.
module mem_array #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end
      // Read register only moves on a read, so it holds across idle/reject cycles.
      if (re_i) begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Single-cycle memory responder: classifies each request, drives one-cycle
// response pulses and saturating access counters around a mem_array.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus_io
);

  acc_kind_e         kind_d, kind_q;
  logic [CntW-1:0]   wr_cnt_d, wr_cnt_q;
  logic [CntW-1:0]   rd_cnt_d, rd_cnt_q;
  logic [DATA_W-1:0] rdata;

  // Classification of the request presented at this edge.
  always_comb begin
    kind_d = IDLE;
    if (bus_io.en) begin
      if (32'(bus_io.addr) >= DEPTH) begin
        kind_d = REJECT;
      end else if (bus_io.wr) begin
        kind_d = WRITE;
      end else begin
        kind_d = READ;
      end
    end
  end

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    unique case (kind_d)
      WRITE:   wr_cnt_d = sat_inc(wr_cnt_q);
      READ:    rd_cnt_d = sat_inc(rd_cnt_q);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kind_q   <= IDLE;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      kind_q   <= kind_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (kind_d == WRITE),
    .re_i    (kind_d == READ),
    .addr_i  (bus_io.addr),
    .wdata_i (bus_io.wdata),
    .rdata_o (rdata)
  );

  // Pulses are gated by rst so a reset in the response cycle suppresses them.
  always_comb begin
    bus_io.wack   = 1'b0;
    bus_io.rvalid = 1'b0;
    bus_io.err    = 1'b0;
    if (!rst) begin
      unique case (kind_q)
        WRITE:   bus_io.wack   = 1'b1;
        READ:    bus_io.rvalid = 1'b1;
        REJECT:  bus_io.err    = 1'b1;
        default: ;
      endcase
    end
    bus_io.rdata  = rdata;
    bus_io.wr_cnt = wr_cnt_q;
    bus_io.rd_cnt = rd_cnt_q;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter: ADDR_W, 6, address width in bits.
REQ-002 Parameter: DATA_W, 8, data width in bits.
REQ-003 Parameter: DEPTH, 48, number of implemented words; legal range 1..2**ADDR_W.
REQ-004 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-005 Port: rst  input  1  reset, synchronous and active-high.
REQ-006 Port: en  input  1  access request, sampled every posedge.
REQ-007 Port: wr  input  1  1 = write, 0 = read; qualified by en.
REQ-008 Port: addr  input  ADDR_W  word address, qualified by en.
REQ-009 Port: wdata  input  DATA_W  write data, qualified by en & wr.
REQ-010 Port: rdata  output  DATA_W  read data, registered.
REQ-011 Port: rvalid  output  1  one-cycle pulse; rdata holds a completed read.
REQ-012 Port: wack  output  1  one-cycle pulse; write completed.
REQ-013 Port: err  output  1  one-cycle pulse; access rejected for out-of-range address.
REQ-014 Port: wr_cnt  output  8  count of completed writes, saturating.
REQ-015 Port: rd_cnt  output  8  count of completed reads, saturating.

Function
REQ-016 The responder SHALL classify each posedge with en=1 as WRITE (wr=1, addr<DEPTH), READ (wr=0, addr<DEPTH) or REJECT (addr>=DEPTH).
REQ-017 A WRITE SHALL store wdata to mem[addr] at that edge and assert wack for exactly the following cycle.
REQ-018 A READ SHALL load mem[addr] into rdata at that edge and assert rvalid for exactly the following cycle; latency is 1 cycle.
REQ-019 A REJECT SHALL leave memory, rdata and both counters unchanged and assert err for exactly the following cycle.
REQ-020 With en=0, wack, rvalid and err SHALL be 0 in the following cycle; rdata SHALL hold its last value.
REQ-021 At most one of wack, rvalid and err SHALL be 1 in any cycle.
REQ-022 Back-to-back accesses SHALL be accepted every cycle with no stall.
REQ-023 A READ at edge N+1 of an address written at edge N SHALL return the data written at edge N.
REQ-024 wr_cnt SHALL increment by 1 on each WRITE and rd_cnt SHALL increment by 1 on each READ; each counter SHALL hold at 255 once reached, with no wrap.
REQ-025 Addresses SHALL be compared as unsigned ADDR_W-bit values; wdata and rdata carry no sign or width conversion.

Reset
REQ-026 When rst=1 at a posedge, all words of mem SHALL clear to 0, and rdata, rvalid, wack, err, wr_cnt and rd_cnt SHALL clear to 0.
REQ-027 Reset SHALL take priority over any simultaneous access; that access SHALL be discarded with no pulse in the following cycle.
REQ-028 If rst is asserted in the cycle after an access, it SHALL suppress that access's response pulse.

Structure
REQ-029 The package mem_resp_pkg SHALL hold the default ADDR_W/DATA_W/DEPTH constants, the counter width, and an access-kind enum {IDLE, WRITE, READ, REJECT}.
REQ-030 Storage SHALL be a sub-module mem_array (DEPTH x DATA_W, one synchronous write port, one registered read port, synchronous clear).
REQ-031 Classification, response pulses and counters SHALL reside in mem_responder.

Verification
REQ-032 Scenario: reset, then write 0xA5 to addr 12 and 0x3C to addr 14, then read 12 and 14 -> wack on 2 cycles; rdata 0xA5 then 0x3C with rvalid; wr_cnt=2, rd_cnt=2.
REQ-033 Scenario: write 0x77 to addr 23 at edge N, read 23 at edge N+1 -> rdata=0x77 with rvalid at N+2.
REQ-034 Scenario: read addr 48 then write addr 56 (DEPTH=48) -> err pulses on 2 cycles; rdata unchanged; counters unchanged; rvalid and wack stay 0.
REQ-035 Scenario: 300 consecutive writes -> wr_cnt=255 and held; wack is 1 every cycle.
REQ-036 Scenario: write 0x11 to addr 5, assert rst, read addr 5 -> rdata=0x00 with rvalid; counters show wr_cnt=0, rd_cnt=1.
REQ-037 Scenario: en=0 with wr toggling and random addr/wdata for 5 cycles -> no pulses, memory and counters unchanged.
